// File: rtl/rdma_req_arb.sv
//==============================================================================
// Module      : rdma_req_arb
// Description : Credit-gated round-robin arbiter merging N_REQ RDMA request
//               streams into one registered output; completions return credits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rdma_req_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 128,
    parameter int N_CRED    = 16,
    localparam int ID_BITS  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_BITS = $clog2(N_CRED + 1)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_REQ-1:0]           s_req_valid,
    output logic [N_REQ-1:0]           s_req_ready,
    input  logic [N_REQ*DATA_BITS-1:0] s_req_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [DATA_BITS-1:0]       m_req_data,
    output logic [ID_BITS-1:0]         m_req_id,
    input  logic                       s_cpl_valid,
    output logic                       s_cpl_ready,
    input  logic [ID_BITS-1:0]         s_cpl_id,
    output logic                       cpl_err
);

    localparam logic [ID_BITS:0]    C_N_REQ_W  = (ID_BITS + 1)'(N_REQ);
    localparam logic [CNT_BITS-1:0] C_CRED_MAX = CNT_BITS'(N_CRED);
    localparam logic [ID_BITS-1:0]  C_LAST_RST = ID_BITS'(N_REQ - 1);

    logic                 m_req_valid_q, m_req_valid_d;
    logic [DATA_BITS-1:0] m_req_data_q,  m_req_data_d;
    logic [ID_BITS-1:0]   m_req_id_q,    m_req_id_d;
    logic                 cpl_err_q,     cpl_err_d;
    logic [ID_BITS-1:0]   last_grant_q,  last_grant_d;
    logic [CNT_BITS-1:0]  credit_q [N_REQ];
    logic [CNT_BITS-1:0]  credit_d [N_REQ];

    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     cred_inc;
    logic [N_REQ-1:0]     cred_dec;
    logic                 out_free;
    logic                 any_elig;
    logic                 grant;
    logic                 cpl_bad;
    logic [ID_BITS-1:0]   grant_idx;
    logic [ID_BITS:0]     scan_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = s_req_valid[i] && (credit_q[i] != '0);
        end
    end

    // Scan from the slot after the last winner, wrapping, first eligible wins.
    always_comb begin
        out_free  = !m_req_valid_q || m_req_ready;
        grant_idx = last_grant_q;
        any_elig  = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = {1'b0, last_grant_q} + (ID_BITS + 1)'(k);
            if (scan_idx >= C_N_REQ_W) begin
                scan_idx = scan_idx - C_N_REQ_W;
            end
            if (!any_elig && eligible[scan_idx[ID_BITS-1:0]]) begin
                any_elig  = 1'b1;
                grant_idx = scan_idx[ID_BITS-1:0];
            end
        end
        grant = aresetn && out_free && any_elig;
    end

    always_comb begin
        s_req_ready = '0;
        if (grant) begin
            s_req_ready[grant_idx] = 1'b1;
        end
    end

    // A completion is rejected if it names a missing requester or would overflow.
    always_comb begin
        cpl_bad = 1'b0;
        if (s_cpl_valid) begin
            if ({1'b0, s_cpl_id} >= C_N_REQ_W) begin
                cpl_bad = 1'b1;
            end else if (credit_q[s_cpl_id] == C_CRED_MAX) begin
                cpl_bad = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cred_inc[i] = s_cpl_valid && !cpl_bad && (s_cpl_id == ID_BITS'(i));
            cred_dec[i] = grant && (grant_idx == ID_BITS'(i));
            credit_d[i] = credit_q[i];
            if (cred_inc[i] && !cred_dec[i]) begin
                credit_d[i] = credit_q[i] + 1'b1;
            end else if (cred_dec[i] && !cred_inc[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        m_req_valid_d = m_req_valid_q;
        m_req_data_d  = m_req_data_q;
        m_req_id_d    = m_req_id_q;
        last_grant_d  = last_grant_q;
        cpl_err_d     = cpl_err_q | cpl_bad;
        if (grant) begin
            m_req_valid_d = 1'b1;
            m_req_data_d  = s_req_data[int'(grant_idx) * DATA_BITS +: DATA_BITS];
            m_req_id_d    = grant_idx;
            last_grant_d  = grant_idx;
        end else if (m_req_ready) begin
            m_req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_req_valid_q <= 1'b0;
            m_req_data_q  <= '0;
            m_req_id_q    <= '0;
            cpl_err_q     <= 1'b0;
            last_grant_q  <= C_LAST_RST;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= C_CRED_MAX;
            end
        end else begin
            m_req_valid_q <= m_req_valid_d;
            m_req_data_q  <= m_req_data_d;
            m_req_id_q    <= m_req_id_d;
            cpl_err_q     <= cpl_err_d;
            last_grant_q  <= last_grant_d;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign m_req_valid = m_req_valid_q;
    assign m_req_data  = m_req_data_q;
    assign m_req_id    = m_req_id_q;
    assign cpl_err     = cpl_err_q;
    assign s_cpl_ready = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_rdma_req_arb.sv
//==============================================================================
// Module      : tb_rdma_req_arb
// Description : Directed self-checking bench for rdma_req_arb (N_CRED=2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rdma_req_arb;

    localparam int N_REQ     = 4;
    localparam int DATA_BITS = 16;
    localparam int N_CRED    = 2;

    logic                       aclk;
    logic                       aresetn;
    logic [N_REQ-1:0]           s_req_valid;
    logic [N_REQ-1:0]           s_req_ready;
    logic [N_REQ*DATA_BITS-1:0] s_req_data;
    logic                       m_req_valid;
    logic                       m_req_ready;
    logic [DATA_BITS-1:0]       m_req_data;
    logic [1:0]                 m_req_id;
    logic                       s_cpl_valid;
    logic                       s_cpl_ready;
    logic [1:0]                 s_cpl_id;
    logic                       cpl_err;

    int n_assert = 0;
    int n_fail   = 0;

    rdma_req_arb #(
        .N_REQ     (N_REQ),
        .DATA_BITS (DATA_BITS),
        .N_CRED    (N_CRED)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .m_req_id    (m_req_id),
        .s_cpl_valid (s_cpl_valid),
        .s_cpl_ready (s_cpl_ready),
        .s_cpl_id    (s_cpl_id),
        .cpl_err     (cpl_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [15:0] data_of(input int id);
        logic [15:0] tbl [4];
        tbl[0] = 16'hA0A0;
        tbl[1] = 16'hB1B1;
        tbl[2] = 16'hC2C2;
        tbl[3] = 16'hD3D3;
        return tbl[id];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int id);
        chk({tag, " valid"}, {31'd0, m_req_valid}, 32'd1);
        chk({tag, " id"}, {30'd0, m_req_id}, 32'(id));
        chk({tag, " data"}, {16'd0, m_req_data}, {16'd0, data_of(id)});
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic cv, input logic [1:0] cid);
        s_req_valid = v;
        m_req_ready = rdy;
        s_cpl_valid = cv;
        s_cpl_id    = cid;
    endtask

    task automatic step();
        @(negedge aclk);
    endtask

    initial begin
        s_req_data = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
        aresetn    = 1'b0;
        drive(4'b1111, 1'b0, 1'b0, 2'd0);

        // Reset state
        step(); step();
        #1;
        chk("rst valid", {31'd0, m_req_valid}, 32'd0);
        chk("rst id", {30'd0, m_req_id}, 32'd0);
        chk("rst data", {16'd0, m_req_data}, 32'd0);
        chk("rst err", {31'd0, cpl_err}, 32'd0);
        chk("rst ready", {28'd0, s_req_ready}, 32'd0);
        chk("cpl ready", {31'd0, s_cpl_ready}, 32'd1);

        // All requesters valid: 0,1,2,3,0,1,2,3 then credits exhausted
        step();
        aresetn = 1'b1;
        drive(4'b1111, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            #1;
            chk("rr ready", {28'd0, s_req_ready}, 32'(1 << (k % 4)));
            if (k == 0) chk("rr first valid", {31'd0, m_req_valid}, 32'd0);
            else chk_out("rr out", (k - 1) % 4);
        end
        step(); #1;
        chk("exhaust ready", {28'd0, s_req_ready}, 32'd0);
        chk_out("rr last", 3);
        step();
        drive(4'b0000, 1'b1, 1'b1, 2'd1);
        #1;
        chk("drain valid", {31'd0, m_req_valid}, 32'd0);

        // Requester 1 alone with two credits returned
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd1);
        step(); drive(4'b0010, 1'b1, 1'b0, 2'd0); #1;
        chk("r1 g1", {28'd0, s_req_ready}, 32'h2);
        step(); #1;
        chk("r1 g2", {28'd0, s_req_ready}, 32'h2);
        chk_out("r1 out1", 1);
        step(); #1;
        chk("r1 nocred", {28'd0, s_req_ready}, 32'h0);
        chk_out("r1 out2", 1);
        step(); drive(4'b0010, 1'b1, 1'b1, 2'd1); #1;
        chk("r1 idle ready", {28'd0, s_req_ready}, 32'h0);
        chk("r1 idle valid", {31'd0, m_req_valid}, 32'd0);
        step(); drive(4'b0010, 1'b1, 1'b0, 2'd0); #1;
        chk("r1 g3", {28'd0, s_req_ready}, 32'h2);
        step(); #1;
        chk("r1 after g3", {28'd0, s_req_ready}, 32'h0);
        chk_out("r1 out3", 1);

        // Refill 0 (x2), 2, 3 then backpressure test
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd0);
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd0);
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd2);
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd3);
        step(); drive(4'b0101, 1'b0, 1'b0, 2'd0); #1;
        chk("bp grant2", {28'd0, s_req_ready}, 32'h4);
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            chk("bp ready", {28'd0, s_req_ready}, 32'h0);
            chk_out("bp hold", 2);
        end
        step(); drive(4'b0101, 1'b1, 1'b0, 2'd0); #1;
        chk("bp release skip2", {28'd0, s_req_ready}, 32'h1);

        // Same-cycle grant and completion on requester 2
        step(); drive(4'b0000, 1'b0, 1'b1, 2'd2); #1;
        chk_out("sc out0", 0);
        chk("sc ready0", {28'd0, s_req_ready}, 32'h0);
        step(); drive(4'b0100, 1'b1, 1'b1, 2'd2); #1;
        chk("sc grant2", {28'd0, s_req_ready}, 32'h4);
        step(); drive(4'b0100, 1'b1, 1'b0, 2'd0); #1;
        chk_out("sc out2a", 2);
        chk("sc credit kept", {28'd0, s_req_ready}, 32'h4);
        step(); #1;
        chk_out("sc out2b", 2);
        chk("sc credit gone", {28'd0, s_req_ready}, 32'h0);

        // Overflowing completion on requester 3 sets sticky error
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd3);
        step(); drive(4'b0000, 1'b1, 1'b1, 2'd3); #1;
        chk("err pre", {31'd0, cpl_err}, 32'd0);
        step(); drive(4'b1000, 1'b1, 1'b0, 2'd0); #1;
        chk("err set", {31'd0, cpl_err}, 32'd1);
        chk("err g1", {28'd0, s_req_ready}, 32'h8);
        step(); #1;
        chk("err g2", {28'd0, s_req_ready}, 32'h8);
        step(); #1;
        chk("err cred max", {28'd0, s_req_ready}, 32'h0);
        chk_out("err out3", 3);
        chk("err sticky", {31'd0, cpl_err}, 32'd1);

        // Reset while a request is stalled in the output register
        step(); drive(4'b0001, 1'b0, 1'b0, 2'd0); #1;
        chk("pre-rst grant0", {28'd0, s_req_ready}, 32'h1);
        step(); aresetn = 1'b0; #1;
        chk_out("pre-rst held", 0);
        chk("in-rst ready", {28'd0, s_req_ready}, 32'h0);
        step(); #1;
        chk("post-rst valid", {31'd0, m_req_valid}, 32'd0);
        chk("post-rst id", {30'd0, m_req_id}, 32'd0);
        chk("post-rst data", {16'd0, m_req_data}, 32'd0);
        chk("post-rst err", {31'd0, cpl_err}, 32'd0);
        step();
        aresetn = 1'b1;
        drive(4'b1110, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            #1;
            chk("rel ready", {28'd0, s_req_ready}, 32'(1 << (1 + k % 3)));
        end
        step(); #1;
        chk("rel exhausted", {28'd0, s_req_ready}, 32'h0);
        chk_out("rel last", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rdma_req_arb.md
RDMA_REQ_ARB -- requirements
Module: rdma_req_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requester ports (2..16).
REQ-002 SHALL have parameter DATA_BITS, default 128, request payload width.
REQ-003 SHALL have parameter N_CRED, default 16, max outstanding requests per requester (1..255).
REQ-004 SHALL derive ID_BITS = max(1, clog2(N_REQ)) and CNT_BITS = clog2(N_CRED+1).
REQ-005 SHALL have ports (name, direction, width, meaning):
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- s_req_valid  in  N_REQ  per-requester request valid.
- s_req_ready  out  N_REQ  per-requester accept.
- s_req_data  in  N_REQ*DATA_BITS  payloads; requester i in bits [i*DATA_BITS +: DATA_BITS].
- m_req_valid  out  1  arbitrated request valid.
- m_req_ready  in  1  downstream accept.
- m_req_data  out  DATA_BITS  arbitrated payload.
- m_req_id  out  ID_BITS  source requester index.
- s_cpl_valid  in  1  completion, returns one credit.
- s_cpl_ready  out  1  constant 1.
- s_cpl_id  in  ID_BITS  requester owning the completion.
- cpl_err  out  1  sticky error flag.

Function
REQ-006 SHALL hold one output register (m_req_valid/data/id); a transfer occurs when m_req_valid and m_req_ready are both 1.
REQ-007 SHALL treat the output register as free when m_req_valid=0, or when a transfer occurs in that cycle.
REQ-008 SHALL mark requester i eligible when s_req_valid[i]=1 and credit[i] > 0.
REQ-009 SHALL grant at most one requester per cycle, and only while the output register is free.
REQ-010 SHALL select round-robin: first eligible index scanning from (last_grant+1) mod N_REQ upward with wrap.
REQ-011 SHALL drive s_req_ready[i]=1 combinationally, in the grant cycle only, for the granted index; all other bits 0.
REQ-012 SHALL, on grant, load s_req_data slice i into m_req_data, load i into m_req_id, and set m_req_valid on the next edge (latency 1 cycle).
REQ-013 SHALL keep m_req_data/m_req_id stable while m_req_valid=1 and m_req_ready=0.
REQ-014 SHALL clear m_req_valid after a transfer when no grant occurs in the same cycle.
REQ-015 SHALL sustain back-to-back grants of 1 per cycle while m_req_ready=1.
REQ-016 SHALL update last_grant to i on grant; with no grant, last_grant is unchanged.
REQ-017 SHALL decrement credit[i] by 1 on grant to i.
REQ-018 SHALL increment credit[s_cpl_id] by 1 on s_cpl_valid.
REQ-019 SHALL leave the credit unchanged when a grant and a completion target the same index in the same cycle.
REQ-020 SHALL, on a completion with credit[s_cpl_id]=N_CRED or s_cpl_id >= N_REQ:
- leave all credits unchanged;
- set cpl_err=1 and hold it until reset.
REQ-021 SHALL make a requester at credit 0 ineligible; that requester is skipped by the round-robin scan without blocking others.

Reset
REQ-022 SHALL, while aresetn=0 at a rising edge, set:
- m_req_valid=0, m_req_data=0, m_req_id=0;
- cpl_err=0;
- every credit[i]=N_CRED;
- last_grant=N_REQ-1, so index 0 has first priority.
REQ-023 SHALL hold s_req_ready=0 throughout any cycle in which aresetn=0.
REQ-024 SHALL discard on reset mid-operation any request held in the output register, with no transfer and no credit return.

Verification
REQ-025 All four requesters valid continuously, m_req_ready=1 -> m_req_id sequence 0,1,2,3,0,... at one per cycle, first m_req_valid one cycle after reset release.
REQ-026 N_CRED=2, requester 1 alone valid, no completions -> exactly 2 grants, then s_req_ready[1]=0; one completion with id 1 -> exactly one further grant.
REQ-027 m_req_ready=0 for 5 cycles with request pending -> m_req_valid=1 and data/id unchanged, s_req_ready all 0; release -> transfer, next grant same cycle.
REQ-028 Requester 2 at credit 0, requesters 0 and 2 valid -> only id 0 granted; a completion for id 2 plus a same-cycle grant to 2 -> credit[2] unchanged.
REQ-029 Completion for id 3 while credit[3]=N_CRED -> cpl_err=1 next cycle, credit[3] stays N_CRED, cpl_err remains 1 until reset.
REQ-030 aresetn=0 while m_req_valid=1 and ready=0 -> next cycle m_req_valid=0, all credits N_CRED, first grant after release to lowest valid index.
